// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared CPU defines: FSM state encodings, exception cause codes and the
// default exception vector used by the multi-cycle controller.
package multi_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_HALT = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EXE  = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_e;

    typedef logic [1:0] exc_type_t;

    localparam exc_type_t EXC_INT  = 2'b00;
    localparam exc_type_t EXC_ADEL = 2'b01;
    localparam exc_type_t EXC_SYS  = 2'b10;
    localparam exc_type_t EXC_RI   = 2'b11;

    localparam logic [31:0] EXC_VECTOR_DFLT = 32'h0000_0100;

endpackage

// File: rtl/evt_counter.sv
// Free-running event counter: counts cycles with inc high, wraps modulo 2^W.
module evt_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q + W'(inc);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU sequencer: steps one instruction through IF/ID/EXE/MEM/WB,
// handles retire/exception bookkeeping and halts at instruction boundaries.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DFLT,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             halt_req,
    input  logic             IF_over,
    input  logic             ID_over,
    input  logic             EXE_over,
    input  logic             MEM_over,
    input  logic             WB_over,
    input  logic             WB_exc,
    input  logic [1:0]       WB_exc_type,
    input  logic [31:0]      WB_pc,
    output logic             IF_valid,
    output logic             ID_valid,
    output logic             EXE_valid,
    output logic             MEM_valid,
    output logic             WB_valid,
    output logic             next_fetch,
    output logic             exc_redirect,
    output logic [31:0]      exc_target,
    output logic [31:0]      epc,
    output logic [1:0]       cause,
    output logic             halted,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] exc_cnt
);

    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    exc_type_t   cause_q, cause_d;
    logic        wb_done;

    // An instruction leaves WB only when WB is the active stage; stray overs are ignored.
    assign wb_done      = (state_q == S_WB) && WB_over;
    assign next_fetch   = wb_done && !WB_exc;
    assign exc_redirect = wb_done && WB_exc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:    if (IF_over)  state_d = S_ID;
            S_ID:    if (ID_over)  state_d = S_EXE;
            S_EXE:   if (EXE_over) state_d = S_MEM;
            S_MEM:   if (MEM_over) state_d = S_WB;
            S_WB:    if (WB_over)  state_d = halt_req ? S_HALT : S_IF;
            S_HALT:  if (!halt_req) state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        epc_d   = epc_q;
        cause_d = cause_q;
        if (exc_redirect) begin
            epc_d   = WB_pc;
            cause_d = WB_exc_type;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IF;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    // Stage enables are a pure decode of the state register.
    assign IF_valid   = (state_q == S_IF);
    assign ID_valid   = (state_q == S_ID);
    assign EXE_valid  = (state_q == S_EXE);
    assign MEM_valid  = (state_q == S_MEM);
    assign WB_valid   = (state_q == S_WB);
    assign halted     = (state_q == S_HALT);
    assign exc_target = EXC_VECTOR;
    assign epc        = epc_q;
    assign cause      = cause_q;

    evt_counter #(.W(CNT_W)) u_retire_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (next_fetch),
        .count  (retire_cnt)
    );

    evt_counter #(.W(CNT_W)) u_exc_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (exc_redirect),
        .count  (exc_cnt)
    );

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed scenarios plus random traffic against
// an instruction-level model; a second instance runs with 4-bit counters.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        halt_req;
    logic [4:0]  ov;
    logic        wb_exc;
    logic [1:0]  wb_type;
    logic [31:0] wb_pc;

    logic        if_v, id_v, exe_v, mem_v, wb_v, nf, er, hlt;
    logic [31:0] exc_tgt, epc_o, ret_o, exc_o;
    logic [1:0]  cause_o;

    logic        if_v4, id_v4, exe_v4, mem_v4, wb_v4, nf4, er4, hlt4;
    logic [31:0] exc_tgt4, epc_o4;
    logic [1:0]  cause_o4;
    logic [3:0]  ret_o4, exc_o4;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk(clk), .resetn(resetn), .halt_req(halt_req),
        .IF_over(ov[0]), .ID_over(ov[1]), .EXE_over(ov[2]), .MEM_over(ov[3]), .WB_over(ov[4]),
        .WB_exc(wb_exc), .WB_exc_type(wb_type), .WB_pc(wb_pc),
        .IF_valid(if_v), .ID_valid(id_v), .EXE_valid(exe_v), .MEM_valid(mem_v), .WB_valid(wb_v),
        .next_fetch(nf), .exc_redirect(er), .exc_target(exc_tgt), .epc(epc_o), .cause(cause_o),
        .halted(hlt), .retire_cnt(ret_o), .exc_cnt(exc_o)
    );

    multi_cycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .halt_req(halt_req),
        .IF_over(ov[0]), .ID_over(ov[1]), .EXE_over(ov[2]), .MEM_over(ov[3]), .WB_over(ov[4]),
        .WB_exc(wb_exc), .WB_exc_type(wb_type), .WB_pc(wb_pc),
        .IF_valid(if_v4), .ID_valid(id_v4), .EXE_valid(exe_v4), .MEM_valid(mem_v4), .WB_valid(wb_v4),
        .next_fetch(nf4), .exc_redirect(er4), .exc_target(exc_tgt4), .epc(epc_o4), .cause(cause_o4),
        .halted(hlt4), .retire_cnt(ret_o4), .exc_cnt(exc_o4)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: which stage the current instruction is in (0..4 = IF..WB, 5 = halted),
    // plus instruction-level bookkeeping.
    int          m_stage;
    longint      m_ret, m_exc;
    logic [31:0] m_epc;
    logic [1:0]  m_cause;
    int          nf_seen, er_seen;
    logic [4:0]  obs_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage = 0;
        m_ret   = 0;
        m_exc   = 0;
        m_epc   = '0;
        m_cause = '0;
    endtask

    task automatic chk_reset_state();
        chk("rst_valids",  {wb_v, mem_v, exe_v, id_v, if_v}, 32'h1);
        chk("rst_valids4", {wb_v4, mem_v4, exe_v4, id_v4, if_v4}, 32'h1);
        chk("rst_pulses",  {nf, er, nf4, er4, hlt, hlt4}, 32'h0);
        chk("rst_retire",  ret_o, 32'h0);
        chk("rst_exc",     exc_o, 32'h0);
        chk("rst_cnt4",    {ret_o4, exc_o4}, 32'h0);
        chk("rst_epc",     epc_o, 32'h0);
        chk("rst_cause",   cause_o, 32'h0);
        chk("exc_target",  exc_tgt, 32'h0000_0100);
        chk("exc_target4", exc_tgt4, 32'h0000_0100);
    endtask

    // One clock cycle: inputs already applied; check at negedge, advance model at posedge.
    task automatic cycle();
        logic [4:0] exp_vld;
        logic       exp_nf, exp_er;
        @(negedge clk);
        exp_vld = (m_stage < 5) ? 5'(1 << m_stage) : 5'b0;
        exp_nf  = (m_stage == 4) && ov[4] && !wb_exc;
        exp_er  = (m_stage == 4) && ov[4] && wb_exc;
        obs_vld = {wb_v, mem_v, exe_v, id_v, if_v};
        chk("valids",     obs_vld, exp_vld);
        chk("valids4",    {wb_v4, mem_v4, exe_v4, id_v4, if_v4}, exp_vld);
        chk("next_fetch", {nf, nf4}, {exp_nf, exp_nf});
        chk("exc_redir",  {er, er4}, {exp_er, exp_er});
        chk("halted",     {hlt, hlt4}, {2{m_stage == 5}});
        chk("retire_cnt", ret_o, m_ret[31:0]);
        chk("exc_cnt",    exc_o, m_exc[31:0]);
        chk("cnt4",       {ret_o4, exc_o4}, {m_ret[3:0], m_exc[3:0]});
        chk("epc",        epc_o, m_epc);
        chk("cause",      {cause_o, cause_o4}, {m_cause, m_cause});
        nf_seen += int'(nf);
        er_seen += int'(er);
        @(posedge clk);
        if (m_stage < 4) begin
            if (ov[m_stage]) m_stage++;
        end else if (m_stage == 4) begin
            if (ov[4]) begin
                if (wb_exc) begin
                    m_exc++;
                    m_epc   = wb_pc;
                    m_cause = wb_type;
                end else begin
                    m_ret++;
                end
                m_stage = halt_req ? 5 : 0;
            end
        end else if (!halt_req) begin
            m_stage = 0;
        end
        #1;
    endtask

    task automatic run_until(input int tgt, input int budget);
        int n = 0;
        while (m_stage != tgt && n < budget) begin
            cycle();
            n++;
        end
        if (m_stage != tgt) chk("timeout", 32'(m_stage), 32'(tgt));
    endtask

    // Asynchronous reset in the middle of a cycle, released just after a rising edge.
    task automatic mid_reset();
        ov = 5'h1f;
        #2 resetn = 1'b0;
        #1;
        chk_reset_state();
        model_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        int exe_hold;
        int er_before;
        longint ret_before;
        resetn   = 1'b0;
        halt_req = 1'b0;
        ov       = 5'h00;
        wb_exc   = 1'b0;
        wb_type  = 2'b00;
        wb_pc    = 32'h0;
        nf_seen  = 0;
        er_seen  = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();
        resetn = 1'b1;

        // All overs tied high: one retire every 5 cycles.
        ov = 5'h1f;
        repeat (20) cycle();
        chk("retire_after20", ret_o, 32'd4);
        chk("nf_pulses20", 32'(nf_seen), 32'd4);

        // Stall EXE for 3 cycles.
        run_until(2, 10);
        exe_hold = 0;
        ov = 5'b11011;
        repeat (3) begin
            cycle();
            exe_hold += int'(obs_vld == 5'b00100);
        end
        ov = 5'h1f;
        cycle();
        exe_hold += int'(obs_vld == 5'b00100);
        chk("exe_hold", 32'(exe_hold), 32'd4);

        // Excepting instruction.
        wb_exc  = 1'b1;
        wb_type = 2'b10;
        wb_pc   = 32'h0000_0040;
        ret_before = m_ret;
        er_before  = er_seen;
        run_until(4, 10);
        cycle();
        chk("exc_epc", epc_o, 32'h40);
        chk("exc_cause", cause_o, 32'd2);
        chk("exc_cnt1", exc_o, 32'd1);
        chk("exc_retire", ret_o, ret_before[31:0]);
        chk("exc_pulses", 32'(er_seen - er_before), 32'd1);
        wb_exc = 1'b0;

        // Halt requested while in ID: instruction completes, then halts.
        run_until(1, 10);
        halt_req = 1'b1;
        run_until(5, 10);
        chk("halted", {hlt, if_v, id_v, exe_v, mem_v, wb_v}, 32'h20);
        repeat (3) cycle();
        halt_req = 1'b0;
        cycle();
        chk("resume_if", {if_v, hlt}, 32'h2);

        // Reset during MEM abandons the instruction.
        run_until(3, 10);
        nf_seen = 0;
        er_seen = 0;
        mid_reset();
        chk("rst_no_pulse", 32'(nf_seen + er_seen), 32'd0);

        // 16 retires: the 4-bit counter wraps.
        ov = 5'h1f;
        repeat (80) cycle();
        chk("retire16", ret_o, 32'd16);
        chk("retire16_w4", {28'h0, ret_o4}, 32'd0);

        // Exception while halting still redirects.
        wb_exc = 1'b1;
        wb_type = 2'b11;
        wb_pc = 32'hdead_beec;
        run_until(4, 10);
        halt_req = 1'b1;
        cycle();
        chk("exc_halt_epc", epc_o, 32'hdead_beec);
        chk("exc_halt_st", {hlt, if_v}, 32'h2);
        halt_req = 1'b0;
        wb_exc = 1'b0;
        cycle();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 5; b++) ov[b] = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
            wb_exc  = ($urandom_range(0, 3) == 0);
            wb_type = 2'($urandom);
            wb_pc   = $urandom;
            if ($urandom_range(0, 499) == 0) mid_reset();
            else cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h0000_0100, meaning the exception redirect target PC.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of each retire/exception counter.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 halt_req  input  1  request to stop at the next instruction boundary.
REQ-006 IF_over, ID_over, EXE_over, MEM_over, WB_over  input  1 each  per-stage completion.
REQ-007 WB_exc  input  1  exception flag carried by the instruction in WB.
REQ-008 WB_exc_type  input  2  exception cause of the instruction in WB.
REQ-009 WB_pc  input  32  PC of the instruction in WB.
REQ-010 IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid  output  1 each  stage enables, one-hot or all-zero.
REQ-011 next_fetch  output  1  one-cycle pulse that advances the PC to the sequential or branch target.
REQ-012 exc_redirect  output  1  one-cycle pulse that loads exc_target into the PC instead.
REQ-013 exc_target  output  32  constant EXC_VECTOR.
REQ-014 epc, cause  output  32, 2  PC and type of the last excepting instruction.
REQ-015 halted  output  1  high while in S_HALT.
REQ-016 retire_cnt, exc_cnt  output  CNT_W each  retired-instruction and exception counts.

Function
REQ-017 FSM states: S_HALT, S_IF, S_ID, S_EXE, S_MEM, S_WB; exactly one stage valid per state, none in S_HALT.
REQ-018 S_IF->S_ID on IF_over; S_ID->S_EXE on ID_over; S_EXE->S_MEM on EXE_over; S_MEM->S_WB on MEM_over; otherwise hold state.
REQ-019 In S_WB with WB_over: go to S_HALT if halt_req is high, else go to S_IF.
REQ-020 S_HALT->S_IF in the first cycle halt_req is low.
REQ-021 halt_req asserted mid-instruction SHALL NOT abort it; it is sampled only at the WB_over boundary.
REQ-022 Stage valids SHALL be decoded combinationally from the state register: zero additional latency, and valid drops in the cycle after the stage's over.
REQ-023 WB_over && !WB_exc: next_fetch=1 for that cycle; retire_cnt+1.
REQ-024 WB_over && WB_exc: exc_redirect=1, next_fetch=0; epc<=WB_pc; cause<=WB_exc_type; exc_cnt+1; retire_cnt unchanged.
REQ-025 next_fetch and exc_redirect SHALL be mutually exclusive and SHALL never assert outside S_WB.
REQ-026 A stage over input arriving while its stage is not valid SHALL be ignored.
REQ-027 Counters SHALL wrap modulo 2^CNT_W, with no saturation and no flag.
REQ-028 An exception with halt_req high SHALL still redirect, update epc/cause, and then enter S_HALT.
REQ-029 Minimum instruction latency SHALL be 5 cycles when every over input is tied high.

Reset
REQ-030 resetn low SHALL immediately force state to S_IF, all outputs except IF_valid to 0, epc=0, cause=0, and both counters to 0.
REQ-031 Reset asserted mid-instruction SHALL abandon that instruction without a retire or exception count.
REQ-032 The first fetch SHALL begin in the first clk edge after resetn deasserts, with IF_valid=1 during reset.

Structure
REQ-033 The state encodings (3-bit), the exception-type codes, and the EXC_VECTOR default SHALL live in the shared CPU defines package.
REQ-034 A single sub-module, evt_counter (parameter W; inputs clk, resetn, inc; output count), SHALL be instantiated twice.
REQ-035 Each output SHALL be driven from registered state or its direct decode; no over-to-valid combinational path is permitted.

Verification
REQ-036 Release reset with all over inputs tied high -> valids cycle IF,ID,EXE,MEM,WB; next_fetch pulses every 5th cycle; retire_cnt=4 after 20 cycles.
REQ-037 Hold EXE_over low for 3 cycles -> EXE_valid stays high for 4 cycles; no other valid asserts; next_fetch is delayed 3 cycles.
REQ-038 WB_exc=1, WB_exc_type=2'b10, WB_pc=32'h0000_0040 at WB_over -> exc_redirect pulses once; epc=0x40; cause=2; exc_cnt=1; retire_cnt unchanged.
REQ-039 Raise halt_req during S_ID -> the instruction completes; then halted=1 and all valids are 0; drop halt_req -> IF_valid=1 on the next cycle.
REQ-040 Assert resetn low during S_MEM -> IF_valid=1 immediately; counters=0; no pulse on next_fetch or exc_redirect.
REQ-041 Run with CNT_W=4 for 16 retires -> retire_cnt wraps to 0.
